// File: rtl/mm_pkg.sv
// mm_pkg: shared definitions for the minute-set controller.
//   - FSM state encoding used by mm_control
//   - default hold / repeat timing and counter width
`timescale 1ns/1ps
package mm_pkg;

  // Button FSM: IDLE waits for a press, HOLD times the first auto-repeat
  // delay, REPEAT emits pulses at the repeat interval.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } mm_state_e;

  localparam int unsigned HOLD_CYCLES_DEF   = 32'd10;
  localparam int unsigned REPEAT_CYCLES_DEF = 32'd5;
  localparam int unsigned CNT_W_DEF         = 32'd8;

endpackage : mm_pkg

// File: rtl/mm_sync.sv
// mm_sync: brings the asynchronous button level into the ck domain and
// flags its rising edge.
//   ck     in  system clock, rising edge
//   reset  in  asynchronous active-low reset
//   din    in  asynchronous level
//   level  out synchronized level (2-FF)
//   rise   out one-cycle high when level goes 0 -> 1
`timescale 1ns/1ps
module mm_sync
  import mm_pkg::*;
(
  input  logic ck,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic r_meta;
  logic r_level;
  logic r_level_d;

  // Two-stage synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_meta    <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_meta    <= din;
      r_level   <= r_meta;
      r_level_d <= r_level;
    end
  end

  assign level = r_level;
  // Delayed copy resets to 0, so a button still held after reset
  // produces a fresh rising edge.
  assign rise  = r_level & ~r_level_d;

endmodule : mm_sync

// File: rtl/mm_control.sv
// mm_control: minute-set controller for the auto-increment digital clock.
// Converts the mm button into one increment on press plus auto-repeat while
// held, routes increments to the clock or alarm minute counter, and merges
// the seconds-rollover tick into the clock minute increment.
//   ck           in  system clock, rising edge
//   reset        in  asynchronous active-low reset
//   mm           in  minute-set button (async level, 1 = pressed)
//   clock_alarm  in  1 = clock minutes, 0 = alarm minutes
//   min          in  one-cycle rollover tick, synchronous to ck
//   up_clock60   out increment to the clock minute counter
//   up_alarm60   out increment to the alarm minute counter
`timescale 1ns/1ps
module mm_control
  import mm_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic ck,
  input  logic reset,
  input  logic mm,
  input  logic clock_alarm,
  input  logic min,
  output logic up_clock60,
  output logic up_alarm60
);

  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: the counter never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v == {CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + CNT_ONE;
    end
    return res;
  endfunction

  logic             w_level;
  logic             w_rise;
  mm_state_e        r_state;
  mm_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_pulse;
  logic             r_pulse_clk;
  logic             r_up_alarm60;
  logic             r_pending;

  mm_sync u_sync (
    .ck    (ck),
    .reset (reset),
    .din   (mm),
    .level (w_level),
    .rise  (w_rise)
  );

  assign w_cnt_inc = sat_inc(r_cnt);

  // Next-state, counter and pulse decode for the button FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pulse     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_pulse     = 1'b1;
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!w_level) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == HOLD_LIM) begin
          w_pulse     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_REPEAT: begin
        if (!w_level) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == REPEAT_LIM) begin
          w_pulse     = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and hold/repeat counter.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered pulse, split by target at the edge that creates it so a
  // clock_alarm change can never drop or double a pulse.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_pulse_clk  <= 1'b0;
      r_up_alarm60 <= 1'b0;
    end else begin
      r_pulse_clk  <= w_pulse & clock_alarm;
      r_up_alarm60 <= w_pulse & ~clock_alarm;
    end
  end

  // A clock-routed pulse that lands on a rollover tick would otherwise be
  // absorbed into the same high cycle; remember it for one extra cycle.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= min & r_pulse_clk;
    end
  end

  // min stays combinational so the rollover adds no latency.
  assign up_clock60 = min | r_pulse_clk | r_pending;
  assign up_alarm60 = r_up_alarm60;

endmodule : mm_control

// File: tb/tb_mm_control.sv
`timescale 1ns/1ps
module tb_mm_control;

  logic ck = 1'b0;
  logic reset;
  logic mm;
  logic clock_alarm;
  logic min;
  logic up_clock60;
  logic up_alarm60;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_clk;
  logic [63:0] m_alm;

  always #5 ck = ~ck;

  mm_control dut (
    .ck          (ck),
    .reset       (reset),
    .mm          (mm),
    .clock_alarm (clock_alarm),
    .min         (min),
    .up_clock60  (up_clock60),
    .up_alarm60  (up_alarm60)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Holds mm for 'len' sampling edges (edge 1..len), records outputs 4 ns
  // after each edge k into bit k of the masks. Per-cycle stimulus is applied
  // 2 ns after edge k: mm release, clock_alarm toggle, min ticks, reset.
  task automatic run(input logic ca, input int len, input int total, input int tog_k,
                     input int min_a, input int min_b, input int rst_k, input int rst_len,
                     output logic [63:0] o_clk, output logic [63:0] o_alm);
    o_clk = '0;
    o_alm = '0;
    @(negedge ck);
    clock_alarm = ca;
    mm = (len > 0);
    for (int k = 1; k <= total; k++) begin
      @(posedge ck);
      #2;
      if (k == len) mm = 1'b0;
      if (k == tog_k) clock_alarm = ~clock_alarm;
      if (k == min_a || k == min_b) min = 1'b1;
      else min = 1'b0;
      if (rst_k > 0 && k == rst_k) reset = 1'b0;
      if (rst_k > 0 && k == rst_k + rst_len) reset = 1'b1;
      #2;
      o_clk[k] = up_clock60;
      o_alm[k] = up_alarm60;
    end
    mm  = 1'b0;
    min = 1'b0;
    repeat (4) @(posedge ck);
  endtask

  initial begin
    reset = 1'b0;
    mm = 1'b0;
    clock_alarm = 1'b0;
    min = 1'b0;

    // 1. reset held low across the first edge, outputs 0
    #6;
    chk("rst_clk", {63'd0, up_clock60}, 64'd0);
    chk("rst_alm", {63'd0, up_alarm60}, 64'd0);
    #1;
    reset = 1'b1;
    run(1'b1, 0, 12, 0, 0, 0, 0, 0, m_clk, m_alm);
    chk("idle_clk", m_clk, 64'd0);
    chk("idle_alm", m_alm, 64'd0);

    // async reset clears a visible pulse mid-cycle
    run(1'b1, 2, 10, 0, 0, 0, 3, 1, m_clk, m_alm);
    chk("async_clk", m_clk, 64'd0);
    chk("async_alm", m_alm, 64'd0);

    // 2. short press: single pulse
    run(1'b1, 2, 12, 0, 0, 0, 0, 0, m_clk, m_alm);
    chk("short_clk", m_clk, 64'd1 << 3);
    chk("short_alm", m_alm, 64'd0);

    // 3. long hold to clock: offsets 0, 10, 15, 20
    run(1'b1, 25, 40, 0, 0, 0, 0, 0, m_clk, m_alm);
    chk("hold_clk", m_clk, (64'd1 << 3) | (64'd1 << 13) | (64'd1 << 18) | (64'd1 << 23));
    chk("hold_clk_alm", m_alm, 64'd0);

    // 4. long hold to alarm
    run(1'b0, 25, 40, 0, 0, 0, 0, 0, m_clk, m_alm);
    chk("hold_alm_clk", m_clk, 64'd0);
    chk("hold_alm", m_alm, (64'd1 << 3) | (64'd1 << 13) | (64'd1 << 18) | (64'd1 << 23));

    // 5. clock_alarm switched 1->0 at offset 12
    run(1'b1, 25, 40, 15, 0, 0, 0, 0, m_clk, m_alm);
    chk("switch_clk", m_clk, (64'd1 << 3) | (64'd1 << 13));
    chk("switch_alm", m_alm, (64'd1 << 18) | (64'd1 << 23));

    // 6. min coinciding with a clock pulse -> 2 cycles; min alone -> 1 cycle
    run(1'b1, 2, 14, 0, 3, 8, 0, 0, m_clk, m_alm);
    chk("min_clk", m_clk, (64'd1 << 3) | (64'd1 << 4) | (64'd1 << 8));
    chk("min_alm", m_alm, 64'd0);

    // min on the alarm side only touches up_clock60
    run(1'b0, 2, 12, 0, 3, 0, 0, 0, m_clk, m_alm);
    chk("min_a_clk", m_clk, 64'd1 << 3);
    chk("min_a_alm", m_alm, 64'd1 << 3);

    // reset at offset 12 with mm held: quiet during reset, fresh first pulse after
    run(1'b1, 26, 36, 0, 0, 0, 15, 2, m_clk, m_alm);
    chk("rsthold_clk", m_clk, (64'd1 << 3) | (64'd1 << 13) | (64'd1 << 20));
    chk("rsthold_alm", m_alm, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mm_control
